rv_exec: RTL and testbench

Integer execute stage of the RV32I core, directly downstream of `decoder`. It consumes the decoded instruction fields and the instruction PC, reads its operands from an internal 32×32 general register file, and computes OP, OP-IMM, LUI and AUIPC results. It writes each result back to the register file and reports it on a one-cycle result strobe. Shifts run on an iterative one-bit-per-cycle shifter unless the fast shifter is compiled in.

---
 rtl/rv_exec.sv | 205 ++++++++++++++++++++
 tb/tb_rv_exec.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_exec.sv
// rv_exec: RV32I integer execute stage (OP, OP-IMM, LUI, AUIPC) with internal 32x32 register file.
// Define RV_EXEC_FAST_SHIFT_EN for a single-cycle barrel shifter; otherwise shifts iterate one bit per cycle.
module rv_exec (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [7:0]  funct7,
    input  logic [20:0] imm,
    input  logic [31:0] pc,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic        out_we,
    output logic        out_illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic [31:0] rf_q [32];
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_result_q, out_result_d;
    logic        out_we_q, out_we_d;
    logic        out_illegal_q, out_illegal_d;

    logic [31:0] rs1_val, rs2_val, op_a, op_b, upper_imm, sll_res, srl_res, alu_res;
    logic [4:0]  shamt;
    logic        is_op, is_opimm, alt, illegal, accept;
    logic        fin, fin_illegal;
    logic [4:0]  fin_rd;
    logic [31:0] fin_val;
    logic        unused_bits;

    function automatic logic [31:0] shift1(input logic [31:0] v, input logic left, input logic arith);
        if (left) return {v[30:0], 1'b0};
        return {arith & v[31], v[31:1]};
    endfunction

    assign rs1_val   = (rs1 == '0) ? '0 : rf_q[rs1];
    assign rs2_val   = (rs2 == '0) ? '0 : rf_q[rs2];
    assign dbg_data  = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];
    assign is_op     = (opcode == OPC_OP);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign alt       = funct7[5];
    assign op_a      = rs1_val;
    assign op_b      = is_op ? rs2_val : {{20{imm[11]}}, imm[11:0]};
    assign shamt     = op_b[4:0];
    assign upper_imm = {imm[19:0], 12'h000};
    assign illegal   = !(is_op || is_opimm || opcode == OPC_LUI || opcode == OPC_AUIPC)
                     || (is_op && alt && funct3 != 3'd0 && funct3 != 3'd5);
    assign accept    = in_valid && in_ready;
    assign unused_bits = ^{funct7[7:6], funct7[4:0], imm[20]};

`ifdef RV_EXEC_FAST_SHIFT_EN
    assign sll_res  = op_a << shamt;
    assign srl_res  = alt ? $unsigned($signed(op_a) >>> shamt) : (op_a >> shamt);
    assign in_ready = 1'b1;
`else
    typedef enum logic {S_IDLE, S_SHIFT} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] sh_val_q, sh_val_d, sh_next;
    logic [4:0]  sh_rd_q, sh_rd_d;
    logic        sh_left_q, sh_left_d, sh_arith_q, sh_arith_d;
    logic        is_shift;

    // The first bit is shifted at acceptance, so amount 1 completes like a non-shift op.
    assign sll_res  = (shamt == '0) ? op_a : shift1(op_a, 1'b1, 1'b0);
    assign srl_res  = (shamt == '0) ? op_a : shift1(op_a, 1'b0, alt);
    assign in_ready = (state_q == S_IDLE);
    assign sh_next  = shift1(sh_val_q, sh_left_q, sh_arith_q);
    assign is_shift = (is_op || is_opimm) && (funct3 == 3'd1 || funct3 == 3'd5);
`endif

    always_comb begin
        alu_res = '0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                case (funct3)
                    3'd0: alu_res = (is_op && alt) ? op_a - op_b : op_a + op_b;
                    3'd1: alu_res = sll_res;
                    3'd2: alu_res = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
                    3'd3: alu_res = (op_a < op_b) ? 32'd1 : 32'd0;
                    3'd4: alu_res = op_a ^ op_b;
                    3'd5: alu_res = srl_res;
                    3'd6: alu_res = op_a | op_b;
                    default: alu_res = op_a & op_b;
                endcase
            end
            OPC_LUI:   alu_res = upper_imm;
            OPC_AUIPC: alu_res = pc + upper_imm;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        out_valid_d   = 1'b0;
        out_rd_d      = out_rd_q;
        out_result_d  = out_result_q;
        out_we_d      = out_we_q;
        out_illegal_d = out_illegal_q;
        wr_en         = 1'b0;
        wr_addr       = rd;
        wr_data       = alu_res;
        fin           = 1'b0;
        fin_rd        = rd;
        fin_val       = alu_res;
        fin_illegal   = illegal;
`ifdef RV_EXEC_FAST_SHIFT_EN
        fin = accept;
`else
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_val_d   = sh_val_q;
        sh_rd_d    = sh_rd_q;
        sh_left_d  = sh_left_q;
        sh_arith_d = sh_arith_q;
        if (state_q == S_IDLE) begin
            if (accept && is_shift && !illegal && shamt > 5'd1) begin
                state_d    = S_SHIFT;
                cnt_d      = shamt - 5'd1;
                sh_val_d   = alu_res;
                sh_rd_d    = rd;
                sh_left_d  = (funct3 == 3'd1);
                sh_arith_d = alt;
            end else begin
                fin = accept;
            end
        end else if (cnt_q == 5'd1) begin
            fin         = 1'b1;
            fin_rd      = sh_rd_q;
            fin_val     = sh_next;
            fin_illegal = 1'b0;
            state_d     = S_IDLE;
        end else begin
            sh_val_d = sh_next;
            cnt_d    = cnt_q - 5'd1;
        end
`endif
        if (fin) begin
            out_valid_d   = 1'b1;
            out_rd_d      = fin_rd;
            out_illegal_d = fin_illegal;
            out_result_d  = fin_illegal ? '0 : fin_val;
            out_we_d      = !fin_illegal && (fin_rd != '0);
            wr_en         = out_we_d;
            wr_addr       = fin_rd;
            wr_data       = fin_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
            out_valid_q   <= 1'b0;
            out_rd_q      <= '0;
            out_result_q  <= '0;
            out_we_q      <= 1'b0;
            out_illegal_q <= 1'b0;
`ifndef RV_EXEC_FAST_SHIFT_EN
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sh_val_q   <= '0;
            sh_rd_q    <= '0;
            sh_left_q  <= 1'b0;
            sh_arith_q <= 1'b0;
`endif
        end else begin
            if (wr_en) rf_q[wr_addr] <= wr_data;
            out_valid_q   <= out_valid_d;
            out_rd_q      <= out_rd_d;
            out_result_q  <= out_result_d;
            out_we_q      <= out_we_d;
            out_illegal_q <= out_illegal_d;
`ifndef RV_EXEC_FAST_SHIFT_EN
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_val_q   <= sh_val_d;
            sh_rd_q    <= sh_rd_d;
            sh_left_q  <= sh_left_d;
            sh_arith_q <= sh_arith_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rd      = out_rd_q;
    assign out_result  = out_result_q;
    assign out_we      = out_we_q;
    assign out_illegal = out_illegal_q;
endmodule

// File: tb/tb_rv_exec.sv
// Directed self-checking bench for rv_exec; expected latencies follow RV_EXEC_FAST_SHIFT_EN.
module tb_rv_exec;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
`ifdef RV_EXEC_FAST_SHIFT_EN
    localparam int FAST = 1;
`else
    localparam int FAST = 0;
`endif

    logic        CLK = 1'b0, RST = 1'b1, in_valid = 1'b0;
    logic        in_ready, out_valid, out_we, out_illegal;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0, dbg_addr = '0, out_rd;
    logic [2:0]  funct3 = '0;
    logic [7:0]  funct7 = '0;
    logic [20:0] imm = '0;
    logic [31:0] pc = '0, out_result, dbg_data;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [6:0] opc; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [7:0] f7;
        logic [20:0] imm; logic [31:0] exp;
    } vec_t;
    vec_t v[10];

    always #5 CLK = ~CLK;

    rv_exec dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .pc(pc), .out_valid(out_valid), .out_rd(out_rd), .out_result(out_result),
        .out_we(out_we), .out_illegal(out_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic drive(input logic [6:0] o, input logic [4:0] d, s1, s2, input logic [2:0] f3,
                         input logic [7:0] f7, input logic [20:0] im, input logic [31:0] p);
        opcode = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im; pc = p;
    endtask

    // Issues one instruction and returns cycles from acceptance to out_valid (-1 on timeout).
    task automatic run_op(input logic [6:0] o, input logic [4:0] d, s1, s2, input logic [2:0] f3,
                          input logic [7:0] f7, input logic [20:0] im, input logic [31:0] p,
                          output int lat);
        int w;
        drive(o, d, s1, s2, f3, f7, im, p);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin step(); w++; end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin step(); lat++; end
        if (!out_valid) lat = -1;
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] val);
        dbg_addr = a; #1; val = dbg_data;
    endtask

    task automatic test_reset();
        int bad;
        logic [31:0] r;
        RST = 1'b1; step(); step(); RST = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_chk++; if ({out_rd, out_result, out_we, out_illegal} !== '0) begin n_fail++; $display("FAIL reset_outs: got rd=%h res=%h we=%b ill=%b expected all 0", out_rd, out_result, out_we, out_illegal); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        bad = 0;
        for (int i = 0; i < 32; i++) begin peek(5'(i), r); if (r !== 32'h0) bad++; end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL reset_regs: got %0d nonzero registers expected 0", bad); end
    endtask

    task automatic test_addi();
        int lat;
        logic [31:0] r;
        run_op(OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 8'h7F, 21'h1FFFFB, 32'h0, lat);
        n_chk++; if (lat != 1) begin n_fail++; $display("FAIL addi_latency: got %0d expected 1", lat); end
        n_chk++; if (out_result !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL addi_result: got %h expected fffffffb", out_result); end
        n_chk++; if (out_we !== 1'b1 || out_rd !== 5'd1) begin n_fail++; $display("FAIL addi_we_rd: got we=%b rd=%0d expected we=1 rd=1", out_we, out_rd); end
        peek(5'd1, r);
        n_chk++; if (r !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL addi_dbg_x1: got %h expected fffffffb", r); end
        step();
        n_chk++; if (out_valid !== 1'b0 || out_result !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL addi_pulse_hold: got valid=%b res=%h expected valid=0 res=fffffffb", out_valid, out_result); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] r;
        run_op(OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 8'h00, 21'h7, 32'h0, lat);
        run_op(OPIMM, 5'd2, 5'd0, 5'd0, 3'd0, 8'h00, 21'h9, 32'h0, lat);
        run_op(OP, 5'd3, 5'd1, 5'd2, 3'd0, 8'h20, 21'h0, 32'h0, lat);
        n_chk++; if (lat != 1 || out_result !== 32'hFFFFFFFE || out_rd !== 5'd3) begin n_fail++; $display("FAIL b2b_sub: got lat=%0d res=%h rd=%0d expected lat=1 res=fffffffe rd=3", lat, out_result, out_rd); end
        run_op(OP, 5'd4, 5'd1, 5'd2, 3'd3, 8'h00, 21'h0, 32'h0, lat);
        n_chk++; if (lat != 1 || out_result !== 32'h1 || out_rd !== 5'd4) begin n_fail++; $display("FAIL b2b_sltu: got lat=%0d res=%h rd=%0d expected lat=1 res=1 rd=4", lat, out_result, out_rd); end
        peek(5'd3, r);
        n_chk++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL b2b_dbg_x3: got %h expected fffffffe", r); end
        peek(5'd4, r);
        n_chk++; if (r !== 32'h1) begin n_fail++; $display("FAIL b2b_dbg_x4: got %h expected 1", r); end
    endtask

    task automatic test_alu();
        int lat;
        logic [31:0] r;
        v[0] = '{OPIMM, 5'd8,  5'd0, 5'd0, 3'd0, 8'h7F, 21'h1FFFFF, 32'hFFFFFFFF};
        v[1] = '{OP,    5'd9,  5'd8, 5'd1, 3'd2, 8'h00, 21'h0,      32'h1};
        v[2] = '{OP,    5'd9,  5'd8, 5'd1, 3'd3, 8'h00, 21'h0,      32'h0};
        v[3] = '{OPIMM, 5'd10, 5'd1, 5'd0, 3'd4, 8'h00, 21'h0FF,    32'hF8};
        v[4] = '{OPIMM, 5'd11, 5'd8, 5'd0, 3'd7, 8'h00, 21'h0F0,    32'hF0};
        v[5] = '{OP,    5'd12, 5'd1, 5'd2, 3'd6, 8'h00, 21'h0,      32'hF};
        v[6] = '{OP,    5'd13, 5'd1, 5'd2, 3'd7, 8'h00, 21'h0,      32'h1};
        v[7] = '{OP,    5'd13, 5'd3, 5'd2, 3'd0, 8'h00, 21'h0,      32'h7};
        v[8] = '{OPIMM, 5'd9,  5'd8, 5'd0, 3'd2, 8'h00, 21'h0,      32'h1};
        v[9] = '{OPIMM, 5'd8,  5'd8, 5'd0, 3'd0, 8'h40, 21'h800,    32'hFFFFF7FF};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].opc, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm, 32'h0, lat);
            peek(v[i].rd, r);
            n_chk++; if (lat != 1 || out_result !== v[i].exp || r !== v[i].exp) begin n_fail++; $display("FAIL alu_vec%0d: got lat=%0d res=%h reg=%h expected lat=1 res=%h", i, lat, out_result, r, v[i].exp); end
        end
    endtask

    task automatic test_shift_edges();
        int lat;
        run_op(OPIMM, 5'd16, 5'd2, 5'd0, 3'd1, 8'h00, 21'h0, 32'h0, lat);
        n_chk++; if (lat != 1 || out_result !== 32'h9) begin n_fail++; $display("FAIL slli0: got lat=%0d res=%h expected lat=1 res=9", lat, out_result); end
        run_op(OPIMM, 5'd16, 5'd2, 5'd0, 3'd1, 8'h00, 21'h1, 32'h0, lat);
        n_chk++; if (lat != 1 || out_result !== 32'h12) begin n_fail++; $display("FAIL slli1: got lat=%0d res=%h expected lat=1 res=12", lat, out_result); end
        run_op(OP, 5'd17, 5'd8, 5'd2, 3'd5, 8'h00, 21'h0, 32'h0, lat);
        n_chk++; if (lat != (FAST ? 1 : 9) || out_result !== 32'h007FFFFB) begin n_fail++; $display("FAIL srl9: got lat=%0d res=%h expected lat=%0d res=007ffffb", lat, out_result, FAST ? 1 : 9); end
        run_op(OP, 5'd17, 5'd8, 5'd2, 3'd5, 8'h20, 21'h0, 32'h0, lat);
        n_chk++; if (lat != (FAST ? 1 : 9) || out_result !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL sra9: got lat=%0d res=%h expected lat=%0d res=fffffffb", lat, out_result, FAST ? 1 : 9); end
        run_op(OP, 5'd17, 5'd1, 5'd2, 3'd1, 8'h00, 21'h0, 32'h0, lat);
        n_chk++; if (lat != (FAST ? 1 : 9) || out_result !== 32'hE00 || out_rd !== 5'd17) begin n_fail++; $display("FAIL sll9: got lat=%0d res=%h rd=%0d expected lat=%0d res=00000e00 rd=17", lat, out_result, out_rd, FAST ? 1 : 9); end
    endtask

    task automatic test_srai();
        int lat, low;
        logic [31:0] r;
        run_op(LUI, 5'd1, 5'd0, 5'd0, 3'd0, 8'h00, 21'h80000, 32'h0, lat);
        n_chk++; if (out_result !== 32'h80000000) begin n_fail++; $display("FAIL lui_x1: got %h expected 80000000", out_result); end
        drive(OPIMM, 5'd5, 5'd1, 5'd0, 3'd5, 8'h20, 21'h0041F, 32'h0);
        in_valid = 1'b1;
        step();
        // Next instruction is held by upstream while the shifter is busy.
        drive(OPIMM, 5'd14, 5'd0, 5'd0, 3'd0, 8'h00, 21'h1, 32'h0);
        lat = 1; low = 0;
        while (!out_valid && lat < 100) begin if (!in_ready) low++; step(); lat++; end
        n_chk++; if (lat != (FAST ? 1 : 31)) begin n_fail++; $display("FAIL srai_latency: got %0d expected %0d", lat, FAST ? 1 : 31); end
        n_chk++; if (low != (FAST ? 0 : 30)) begin n_fail++; $display("FAIL srai_ready_low: got %0d expected %0d", low, FAST ? 0 : 30); end
        n_chk++; if (out_result !== 32'hFFFFFFFF || out_rd !== 5'd5) begin n_fail++; $display("FAIL srai_result: got res=%h rd=%0d expected res=ffffffff rd=5", out_result, out_rd); end
        step();
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_rd !== 5'd14 || out_result !== 32'h1) begin n_fail++; $display("FAIL held_after_shift: got valid=%b rd=%0d res=%h expected valid=1 rd=14 res=1", out_valid, out_rd, out_result); end
        peek(5'd5, r);
        n_chk++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL srai_dbg_x5: got %h expected ffffffff", r); end
    endtask

    task automatic test_lui_auipc();
        int lat;
        logic [31:0] r;
        run_op(LUI, 5'd0, 5'd0, 5'd0, 3'd0, 8'h00, 21'h12345, 32'h0, lat);
        n_chk++; if (lat != 1 || out_we !== 1'b0 || out_result !== 32'h12345000) begin n_fail++; $display("FAIL lui_x0: got lat=%0d we=%b res=%h expected lat=1 we=0 res=12345000", lat, out_we, out_result); end
        peek(5'd0, r);
        n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL lui_dbg_x0: got %h expected 0", r); end
        run_op(AUIPC, 5'd6, 5'd0, 5'd0, 3'd0, 8'h00, 21'h1, 32'h100, lat);
        peek(5'd6, r);
        n_chk++; if (out_result !== 32'h1100 || r !== 32'h1100 || out_we !== 1'b1) begin n_fail++; $display("FAIL auipc_x6: got res=%h reg=%h we=%b expected res=1100 reg=1100 we=1", out_result, r, out_we); end
    endtask

    task automatic test_illegal();
        int lat;
        logic [31:0] r;
        run_op(7'b0000011, 5'd1, 5'd2, 5'd0, 3'd2, 8'h00, 21'h4, 32'h0, lat);
        n_chk++; if (lat != 1 || out_illegal !== 1'b1 || out_we !== 1'b0 || out_result !== 32'h0) begin n_fail++; $display("FAIL illegal_outs: got lat=%0d ill=%b we=%b res=%h expected lat=1 ill=1 we=0 res=0", lat, out_illegal, out_we, out_result); end
        peek(5'd1, r);
        n_chk++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL illegal_no_write: got x1=%h expected 80000000", r); end
        run_op(OPIMM, 5'd7, 5'd0, 5'd0, 3'd0, 8'h00, 21'h3, 32'h0, lat);
        n_chk++; if (out_illegal !== 1'b0 || out_result !== 32'h3) begin n_fail++; $display("FAIL illegal_clear: got ill=%b res=%h expected ill=0 res=3", out_illegal, out_result); end
    endtask

    task automatic test_reset_mid_shift();
        int pulses;
        logic [31:0] r;
        drive(OPIMM, 5'd18, 5'd2, 5'd0, 3'd1, 8'h00, 21'h14, 32'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k < 5; k++) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        n_chk++; if ({out_valid, out_rd, out_result, out_we, out_illegal} !== '0) begin n_fail++; $display("FAIL rst_mid_outs: got valid=%b rd=%0d res=%h we=%b ill=%b expected all 0", out_valid, out_rd, out_result, out_we, out_illegal); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
        peek(5'd18, r);
        n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL rst_mid_x18: got %h expected 0", r); end
        pulses = 0;
        for (int k = 0; k < 25; k++) begin step(); if (out_valid) pulses++; end
        peek(5'd18, r);
        n_chk++; if (pulses != 0 || r !== 32'h0) begin n_fail++; $display("FAIL rst_mid_abandon: got pulses=%0d x18=%h expected 0 and 0", pulses, r); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_alu();
        test_shift_edges();
        test_srai();
        test_lui_auipc();
        test_illegal();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
